// File: rtl/store_buffer_pkg.sv
// Shared memory-system constants for the core, data_memory and store_buffer.
//   MEM_IDX_W : data_memory index width (word address bits actually decoded)
//   DATA_W    : memory data width
package store_buffer_pkg;
  localparam int unsigned MEM_IDX_W = 7;
  localparam int unsigned DATA_W    = 32;
endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match priority selector for store-to-load forwarding.
// Purely combinational.
//   entry_idx : low address bits of every buffer slot
//   occupied  : per-slot occupancy mask
//   head      : slot of the oldest entry
//   ld_idx    : low address bits of the load
//   hit       : at least one occupied slot matches
//   sel       : one-hot select of the youngest matching slot
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MATCH_W = MEM_IDX_W
) (
  input  logic [DEPTH-1:0][MATCH_W-1:0] entry_idx,
  input  logic [DEPTH-1:0]              occupied,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [MATCH_W-1:0]            ld_idx,
  output logic                          hit,
  output logic [DEPTH-1:0]              sel
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] pos;

  // Walk slots oldest to youngest starting at head; a later match overrides
  // an earlier one, so the last survivor is the entry closest to tail.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    pos = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (occupied[pos] && (entry_idx[pos] == ld_idx)) begin
        hit      = 1'b1;
        sel      = '0;
        sel[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO of committed stores between the memory stage and data_memory.
// Drains one store per cycle when no load owns the memory port, and forwards
// the youngest matching buffered data to loads.
//   clk, reset         : clock, synchronous active-high reset
//   st_valid/addr/data : store request; st_ready = room available
//   ld_valid/addr      : load request (owns the memory port this cycle)
//   ld_data, ld_hit    : load result and "came from buffer" flag
//   mem_store/address/data_in, mem_data_out : data_memory interface
//   empty, count       : occupancy status
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = store_buffer_pkg::DATA_W,
  parameter int unsigned MATCH_W = MEM_IDX_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_hit,
  output logic                       mem_store,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count_q;

  logic                         enq, drain;
  logic [DEPTH-1:0]             occupied;
  logic [DEPTH-1:0][MATCH_W-1:0] entry_idx;
  logic [PTR_W-1:0]             rel;
  logic                         fwd_hit;
  logic [DEPTH-1:0]             fwd_sel;
  logic [DATA_W-1:0]            fwd_data;

  assign st_ready = (count_q < CNT_W'(DEPTH));
  assign enq      = st_valid && st_ready;
  // Drain is masked during reset so a pending entry is never written.
  assign drain    = !reset && (count_q != '0) && !ld_valid;

  assign empty = (count_q == '0);
  assign count = count_q;

  assign mem_store   = drain;
  assign mem_data_in = data_q[head];
  assign mem_address = ld_valid ? ld_addr :
                       ((count_q != '0) ? addr_q[head] : '0);

  // A slot is occupied when its distance from head is below count.
  always_comb begin
    occupied  = '0;
    entry_idx = '0;
    rel       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel          = PTR_W'(i) - head;
      occupied[i]  = (CNT_W'(rel) < count_q);
      entry_idx[i] = addr_q[i][MATCH_W-1:0];
    end
  end

  sb_fwd_match #(
    .DEPTH   (DEPTH),
    .MATCH_W (MATCH_W)
  ) u_fwd_match (
    .entry_idx (entry_idx),
    .occupied  (occupied),
    .head      (head),
    .ld_idx    (ld_addr[MATCH_W-1:0]),
    .hit       (fwd_hit),
    .sel       (fwd_sel)
  );

  always_comb begin
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (fwd_sel[i]) fwd_data = fwd_data | data_q[i];
    end
  end

  assign ld_hit  = !reset && ld_valid && fwd_hit;
  assign ld_data = ld_hit ? fwd_data : mem_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq)   tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      count_q <= count_q + CNT_W'(enq) - CNT_W'(drain);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count/head.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_data;
  logic        ld_hit;
  logic        mem_store;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH   (4),
    .ADDR_W  (32),
    .DATA_W  (32),
    .MATCH_W (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_ready     (st_ready),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_hit       (ld_hit),
    .mem_store    (mem_store),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .empty        (empty),
    .count        (count)
  );

  // data_memory model: 128 words, combinational read, write on posedge.
  logic [31:0] mem [128];
  logic        mem_init;

  function automatic logic [31:0] img(input int i);
    return 32'h4000 + 32'(i) * 32'h111;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= img(i);
    end else if (mem_store) begin
      mem[mem_address[6:0]] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_address[6:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are checked #1 later.
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    @(negedge clk);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
    #1;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        lv;
    logic [31:0] la;
    logic [2:0]  cnt;
    logic        rdy;
    logic        ms;
    logic [31:0] ma;
    logic [31:0] md;
    logic        hit;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Forwarding / drain vectors, starting from an empty buffer.
    tbl[0] = '{1'b1, 32'h4, 32'h11, 1'b1, 32'h4,  3'd0, 1'b1, 1'b0, 32'h4,  32'h0,  1'b0, 32'h4444};
    tbl[1] = '{1'b1, 32'h4, 32'h22, 1'b1, 32'h4,  3'd1, 1'b1, 1'b0, 32'h4,  32'h0,  1'b1, 32'h11};
    tbl[2] = '{1'b0, 32'h0, 32'h0,  1'b1, 32'h4,  3'd2, 1'b1, 1'b0, 32'h4,  32'h0,  1'b1, 32'h22};
    tbl[3] = '{1'b0, 32'h0, 32'h0,  1'b1, 32'h84, 3'd2, 1'b1, 1'b0, 32'h84, 32'h0,  1'b1, 32'h22};
    tbl[4] = '{1'b0, 32'h0, 32'h0,  1'b1, 32'h5,  3'd2, 1'b1, 1'b0, 32'h5,  32'h0,  1'b0, 32'h4555};
    tbl[5] = '{1'b0, 32'h0, 32'h0,  1'b0, 32'h0,  3'd2, 1'b1, 1'b1, 32'h4,  32'h11, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h0, 32'h0,  1'b1, 32'h4,  3'd1, 1'b1, 1'b0, 32'h4,  32'h0,  1'b1, 32'h22};
    tbl[7] = '{1'b0, 32'h0, 32'h0,  1'b0, 32'h0,  3'd1, 1'b1, 1'b1, 32'h4,  32'h22, 1'b0, 32'h0};
    tbl[8] = '{1'b0, 32'h0, 32'h0,  1'b0, 32'h0,  3'd0, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0};
    tbl[9] = '{1'b0, 32'h0, 32'h0,  1'b1, 32'h4,  3'd0, 1'b1, 1'b0, 32'h4,  32'h0,  1'b0, 32'h22};

    mem_init = 1'b1;
    reset    = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    mem_init = 1'b0;
    #1;
    chk("rst_st_ready", st_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_store", mem_store, 0);
    chk("rst_ld_hit", ld_hit, 0);

    // Basic drain
    drive(1, 32'h10, 32'hDEADBEEF, 0, 0);
    chk("bd_idle_store", mem_store, 0);
    drive(0, 0, 0, 0, 0);
    chk("bd_mem_store", mem_store, 1);
    chk("bd_mem_address", mem_address, 32'h10);
    chk("bd_mem_data_in", mem_data_in, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0);
    chk("bd_mem_written", mem[7'h10], 32'hDEADBEEF);
    chk("bd_empty", empty, 1);

    // Forwarding table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la);
      chk($sformatf("fw%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("fw%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("fw%0d_ready", i), st_ready, tbl[i].rdy);
      chk($sformatf("fw%0d_mem_store", i), mem_store, tbl[i].ms);
      chk($sformatf("fw%0d_mem_address", i), mem_address, tbl[i].ma);
      chk($sformatf("fw%0d_ld_hit", i), ld_hit, tbl[i].hit);
      if (tbl[i].ms) chk($sformatf("fw%0d_mem_data_in", i), mem_data_in, tbl[i].md);
      if (tbl[i].lv) chk($sformatf("fw%0d_ld_data", i), ld_data, tbl[i].ld);
    end

    // Full / backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h20 + 32'(i), 32'hA0 + 32'(i), 1, 32'h7F);
      chk($sformatf("full_fill%0d_ready", i), st_ready, 1);
      chk($sformatf("full_fill%0d_ld_hit", i), ld_hit, 0);
    end
    drive(1, 32'h30, 32'hEEE, 1, 32'h7F);
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    chk("full_no_store", mem_store, 0);
    drive(1, 32'h30, 32'hEEE, 0, 0);
    chk("full_ignored_count", count, 4);
    chk("full_drain_ready", st_ready, 0);
    chk("full_drain0_store", mem_store, 1);
    chk("full_drain0_addr", mem_address, 32'h20);
    chk("full_drain0_data", mem_data_in, 32'hA0);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("full_drain%0d_count", i), count, 3'(4 - i));
      chk($sformatf("full_drain%0d_ready", i), st_ready, 1);
      chk($sformatf("full_drain%0d_store", i), mem_store, 1);
      chk($sformatf("full_drain%0d_addr", i), mem_address, 32'h20 + 32'(i));
      chk($sformatf("full_drain%0d_data", i), mem_data_in, 32'hA0 + 32'(i));
    end
    drive(0, 0, 0, 0, 0);
    chk("full_done_count", count, 0);
    chk("full_done_store", mem_store, 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("full_mem%0d", i), mem[7'h20 + 7'(i)], 32'hA0 + 32'(i));
    chk("full_refused_not_written", mem[7'h30], img(32'h30));

    // Concurrent enqueue and drain at count=2, across pointer wrap
    drive(1, 32'h40, 32'h1000, 1, 32'h7F);
    drive(1, 32'h41, 32'h1001, 1, 32'h7F);
    for (int i = 2; i < 12; i++) begin
      drive(1, 32'h40 + 32'(i), 32'h1000 + 32'(i), 0, 0);
      chk($sformatf("cc%0d_count", i), count, 2);
      chk($sformatf("cc%0d_store", i), mem_store, 1);
      chk($sformatf("cc%0d_addr", i), mem_address, 32'h40 + 32'(i - 2));
      chk($sformatf("cc%0d_data", i), mem_data_in, 32'h1000 + 32'(i - 2));
    end
    for (int j = 10; j < 12; j++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("cc_tail%0d_count", j), count, 3'(12 - j));
      chk($sformatf("cc_tail%0d_addr", j), mem_address, 32'h40 + 32'(j));
      chk($sformatf("cc_tail%0d_data", j), mem_data_in, 32'h1000 + 32'(j));
    end
    drive(0, 0, 0, 0, 0);
    chk("cc_empty", empty, 1);
    for (int i = 0; i < 12; i++)
      chk($sformatf("cc_mem%0d", i), mem[7'h40 + 7'(i)], 32'h1000 + 32'(i));

    // Reset mid-operation
    for (int i = 0; i < 3; i++)
      drive(1, 32'h50 + 32'(i), 32'h5000 + 32'(i), 1, 32'h7F);
    @(negedge clk);
    reset    = 1'b1;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    #1;
    chk("rmid_pre_count", count, 3);
    chk("rmid_in_reset_store", mem_store, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rmid_count", count, 0);
    chk("rmid_empty", empty, 1);
    chk("rmid_store", mem_store, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0);
      chk($sformatf("rmid_idle%0d_store", i), mem_store, 0);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("rmid_mem%0d", i), mem[7'h50 + 7'(i)], img(32'h50 + i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of committed stores between the multi-cycle core's memory stage and data_memory.
- Decouples store issue from memory writes.
- Retires one buffered store per cycle whenever the single memory address port is not needed by a load.
- Forwards buffered data to loads so that loads always see the latest program-order value.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two, at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MATCH_W, 7, low address bits compared for forwarding; equals data_memory's index width, so aliasing matches the memory exactly.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  core presents a store this cycle.
- st_addr  input  ADDR_W  store address.
- st_data  input  DATA_W  store data.
- st_ready  output  1  buffer can accept a store (count < DEPTH).
- ld_valid  input  1  core performs a load this cycle; owns the memory port.
- ld_addr  input  ADDR_W  load address.
- ld_data  output  DATA_W  load result: forwarded data or memory data.
- ld_hit  output  1  ld_data came from the buffer.
- mem_store  output  1  to data_memory store_instruction.
- mem_address  output  ADDR_W  to data_memory address.
- mem_data_in  output  DATA_W  to data_memory data_memory_in.
- mem_data_out  input  DATA_W  from data_memory data_memory_out (combinational read).
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage: circular array of {addr, data}, plus head/tail pointers of $clog2(DEPTH) bits (natural wrap) and count.
- Reset (synchronous): head=0, tail=0, count=0. Outputs: st_ready=1, empty=1, mem_store=0, ld_hit=0. Pending entries are discarded and never written to memory, including on reset mid-drain.
- Enqueue: on posedge when st_valid && st_ready && !reset, write the entry at tail and advance tail.
- st_ready depends only on the registered count. When full, a store is refused even if a drain occurs that cycle. st_valid while !st_ready is ignored; the core holds it.
- Drain, combinational:
  - Condition: count > 0 && !ld_valid.
  - Outputs: mem_store=1, mem_address=head.addr, mem_data_in=head.data.
  - data_memory writes at the same posedge, and head advances then. One store per cycle, strictly FIFO order.
- Load, combinational:
  - Port ownership: ld_valid=1 forces mem_store=0 and mem_address=ld_addr.
  - Match: an occupied entry with addr[MATCH_W-1:0] == ld_addr[MATCH_W-1:0].
  - If any entry matches, ld_hit=1 and ld_data = the youngest match (closest to tail). Otherwise ld_hit=0 and ld_data=mem_data_out.
- No-load cycles: when ld_valid=0, mem_address = head.addr if non-empty, else 0, and ld_hit=0.
- Same-cycle store and load: a store enqueued in the same cycle as a load is not forwarded to that load. The core never issues a dependent load in the same cycle.
- Simultaneous enqueue and drain: count unchanged and both pointers advance. Valid at any count below DEPTH.
- Starvation: continuous ld_valid stalls draining indefinitely. The core guarantees load-free cycles; empty is the fence/halt indicator.
- Latency:
  - Store to memory: at least 1 cycle after enqueue.
  - Load: combinational, zero cycles.

Decomposition:
- Shared memory-system package holds MEM_IDX_W=7 and DATA_W=32, shared with data_memory and the core.
- One sub-module, sb_fwd_match: purely combinational youngest-match priority selector. Inputs are entry addresses, an occupancy mask, head and ld_addr. Outputs are hit and a one-hot select.

Test Plan:
- Reset: assert reset for 2 cycles -> st_ready=1, empty=1, count=0, mem_store=0, ld_hit=0.
- Basic drain: ld_valid=0; enqueue (0x10, 0xDEADBEEF) -> next cycle mem_store=1, mem_address=0x10, mem_data_in=0xDEADBEEF; after that edge mem[0x10]=0xDEADBEEF and empty=1.
- Forwarding: ld_valid=1; enqueue (0x4, 0x11) then (0x4, 0x22).
  - Load 0x4 -> ld_hit=1, ld_data=0x22.
  - Load 0x84 (aliases in low 7 bits) -> ld_hit=1, ld_data=0x22.
  - Load 0x5 -> ld_hit=0, ld_data = memory image value at index 5 (0x00004555).
- Full/backpressure: ld_valid=1; enqueue 4 stores A..D -> count=4, st_ready=0; a 5th st_valid is ignored, count stays 4.
  - Drop ld_valid -> mem writes A,B,C,D on 4 consecutive cycles.
  - st_ready=1 from the cycle after the first drain.
- Concurrent enqueue and drain at count=2 with ld_valid=0 -> count stays 2 and order is preserved across pointer wrap (12 stores total, memory contents checked).
- Reset mid-operation: 3 entries buffered and ld_valid=1; pulse reset -> no mem_store afterwards, count=0, memory unchanged.
